// File: rtl/ac_motor_pwm_deadtime_if.sv
// Gate-drive bus between the PWM/dead-time block and its environment.
// Carries the carrier, the references, the control inputs and the per-leg gate outputs.
interface ac_motor_pwm_deadtime_if #(
  parameter int unsigned N    = 3,
  parameter int unsigned W    = 24,
  parameter int unsigned DT_W = 8
);
  logic                enable;
  logic                trip;
  logic                lock;
  logic signed [W-1:0] triangle;
  logic [N*W-1:0]      ref_in;
  logic [DT_W-1:0]     dead_cyc;
  logic [N-1:0]        out_hi;
  logic [N-1:0]        out_lo;
  logic [N-1:0]        en;
  logic                tripped;

  modport master (
    output enable, trip, lock, triangle, ref_in, dead_cyc,
    input  out_hi, out_lo, en, tripped
  );

  modport slave (
    input  enable, trip, lock, triangle, ref_in, dead_cyc,
    output out_hi, out_lo, en, tripped
  );
endinterface

// File: rtl/ac_motor_pwm_deadtime.sv
// N-leg sine/triangle PWM comparator with shadowed references, per-leg dead time
// and a latched fault trip driving complementary high/low gate signals.
module ac_motor_pwm_deadtime #(
  parameter int unsigned N    = 3,
  parameter int unsigned W    = 24,
  parameter int unsigned DT_W = 8
) (
  input logic                     clk,
  input logic                     reset,
  ac_motor_pwm_deadtime_if.slave  bus
);

  typedef enum logic [1:0] {S_OFF, S_HI, S_LO, S_DT} state_t;

  logic            r_tripped;
  logic            w_override;
  logic [DT_W-1:0] w_dt_load;
  logic [N-1:0]    w_hi;
  logic [N-1:0]    w_lo;
  logic [N-1:0]    w_en;

  assign w_override = !bus.enable || r_tripped || bus.trip;
  // A zero dead time still costs one blanking cycle so HI and LO never abut.
  assign w_dt_load  = (bus.dead_cyc == '0) ? DT_W'(1) : bus.dead_cyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tripped <= 1'b0;
    end else if (bus.trip) begin
      r_tripped <= 1'b1;
    end else if (!bus.enable) begin
      r_tripped <= 1'b0;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_leg
    state_t              r_state;
    state_t              w_state_nxt;
    logic [DT_W-1:0]     r_cnt;
    logic [DT_W-1:0]     w_cnt_nxt;
    logic signed [W-1:0] r_ref_q;
    logic signed [W-1:0] w_ref_in;
    logic                r_demand;
    logic                r_hi;
    logic                r_lo;
    logic                r_en;

    assign w_ref_in = bus.ref_in[g*W +: W];

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_override) begin
        w_state_nxt = S_OFF;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          S_OFF: begin
            w_state_nxt = S_DT;
            w_cnt_nxt   = w_dt_load;
          end
          S_HI: begin
            if (!r_demand) begin
              w_state_nxt = S_DT;
              w_cnt_nxt   = w_dt_load;
            end
          end
          S_LO: begin
            if (r_demand) begin
              w_state_nxt = S_DT;
              w_cnt_nxt   = w_dt_load;
            end
          end
          S_DT: begin
            // Exit side follows the demand present now, not the one at entry.
            if (r_cnt == DT_W'(1)) begin
              w_state_nxt = r_demand ? S_HI : S_LO;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - DT_W'(1);
            end
          end
          default: begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state  <= S_OFF;
        r_cnt    <= '0;
        r_ref_q  <= '0;
        r_demand <= 1'b0;
        r_hi     <= 1'b0;
        r_lo     <= 1'b0;
        r_en     <= 1'b0;
      end else begin
        if (bus.lock || (r_state == S_OFF && bus.enable)) begin
          r_ref_q <= w_ref_in;
        end
        r_demand <= (r_ref_q > bus.triangle);
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_hi     <= (w_state_nxt == S_HI);
        r_lo     <= (w_state_nxt == S_LO);
        r_en     <= (w_state_nxt != S_OFF);
      end
    end

    assign w_hi[g] = r_hi;
    assign w_lo[g] = r_lo;
    assign w_en[g] = r_en;
  end

  assign bus.out_hi  = w_hi;
  assign bus.out_lo  = w_lo;
  assign bus.en      = w_en;
  assign bus.tripped = r_tripped;

endmodule

// File: tb/tb_ac_motor_pwm_deadtime.sv
// Randomized bench for ac_motor_pwm_deadtime: a gate-level behavioural model predicts
// every leg's outputs each cycle, plus directed latency/dead-time/trip checks.
module tb_ac_motor_pwm_deadtime;
  localparam int unsigned N    = 3;
  localparam int unsigned W    = 24;
  localparam int unsigned DT_W = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err = 0;

  ac_motor_pwm_deadtime_if #(.N(N), .W(W), .DT_W(DT_W)) bus ();

  ac_motor_pwm_deadtime #(.N(N), .W(W), .DT_W(DT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the gate pins directly plus remaining blanking cycles.
  logic signed [W-1:0] m_refq [N];
  bit                  m_dem  [N];
  bit                  m_hi   [N];
  bit                  m_lo   [N];
  bit                  m_en   [N];
  int                  m_left [N];
  bit                  m_trip;

  always @(posedge clk) begin
    bit override;
    int blank;
    logic signed [W-1:0] r;
    override = !bus.enable || m_trip || bus.trip;
    blank    = (bus.dead_cyc == 0) ? 1 : int'(bus.dead_cyc);
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_refq[i] = '0; m_dem[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_en[i] = 0; m_left[i] = 0;
      end else begin
        bit dem_old;
        bit was_off;
        dem_old = m_dem[i];
        was_off = !m_en[i];
        m_dem[i] = (m_refq[i] > bus.triangle);
        r = bus.ref_in[i*W +: W];
        if (bus.lock || (was_off && bus.enable)) m_refq[i] = r;
        if (override) begin
          m_hi[i] = 0; m_lo[i] = 0; m_en[i] = 0; m_left[i] = 0;
        end else if (was_off) begin
          m_en[i] = 1; m_left[i] = blank;
        end else if (m_left[i] > 0) begin
          if (m_left[i] == 1) begin m_hi[i] = dem_old; m_lo[i] = !dem_old; end
          m_left[i]--;
        end else if ((m_hi[i] && !dem_old) || (m_lo[i] && dem_old)) begin
          m_hi[i] = 0; m_lo[i] = 0; m_left[i] = blank;
        end
      end
    end
    if (reset) m_trip = 0;
    else if (bus.trip) m_trip = 1;
    else if (!bus.enable) m_trip = 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic step();
    logic [N-1:0] e_hi, e_lo, e_en;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      e_hi[i] = m_hi[i]; e_lo[i] = m_lo[i]; e_en[i] = m_en[i];
    end
    check("out_hi", 32'(bus.out_hi), 32'(e_hi));
    check("out_lo", 32'(bus.out_lo), 32'(e_lo));
    check("en", 32'(bus.en), 32'(e_en));
    check("tripped", 32'(bus.tripped), 32'(m_trip));
    check("no_shoot", 32'(bus.out_hi & bus.out_lo), 32'd0);
  endtask

  task automatic set_refs(input int v0, input int v1, input int v2);
    logic signed [W-1:0] a, b, c;
    a = W'(v0); b = W'(v1); c = W'(v2);
    bus.ref_in = {c, b, a};
  endtask

  int tri_v;
  int dir;
  int k;

  initial begin
    reset = 1'b1;
    bus.enable = 0; bus.trip = 0; bus.lock = 0; bus.triangle = '0;
    bus.ref_in = '0; bus.dead_cyc = 8'd4;
    step(); step();
    reset = 1'b0;
    check("rst_en", 32'(bus.en), 32'd0);
    check("rst_trip", 32'(bus.tripped), 32'd0);

    // Directed: ref=+1000, triangle crosses 1000, dead time 4.
    set_refs(1000, 1000, 1000);
    bus.lock = 1; bus.enable = 1; bus.triangle = '0;
    step();
    bus.lock = 0;
    for (int i = 0; i < 12; i++) step();
    check("dir_hi", 32'(bus.out_hi), 32'h7);
    bus.triangle = W'(1000);
    k = 0;
    do begin step(); k++; end while (bus.out_hi[0] && k < 20);
    check("hi_fall_lat", 32'(k), 32'd2);
    k = 0;
    do begin step(); k++; end while (!bus.out_lo[0] && k < 20);
    check("dt_len", 32'(k), 32'd4);

    // Short demand pulse inside a long dead time: leg returns to HI, no lo pulse.
    bus.dead_cyc = 8'd10;
    bus.triangle = '0;
    step();
    bus.triangle = W'(2000);
    step(); step();
    bus.triangle = '0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i < 8) check("glitch_lo", 32'(bus.out_lo), 32'd0);
    end
    check("glitch_hi", 32'(bus.out_hi), 32'h7);

    // ref change without lock has no effect until lock.
    set_refs(-3000, -3000, -3000);
    for (int i = 0; i < 6; i++) step();
    check("shadow_hold", 32'(bus.out_hi), 32'h7);
    bus.lock = 1;
    step();
    bus.lock = 0;
    for (int i = 0; i < 15; i++) step();
    check("shadow_load", 32'(bus.out_lo), 32'h7);

    // Trip: latch holds while enable stays high, clears after enable cycles low.
    bus.trip = 1;
    step();
    bus.trip = 0;
    check("trip_off", 32'(bus.en), 32'd0);
    check("trip_flag", 32'(bus.tripped), 32'd1);
    for (int i = 0; i < 5; i++) step();
    check("trip_hold", 32'(bus.en), 32'd0);
    bus.enable = 0;
    step();
    check("trip_clr", 32'(bus.tripped), 32'd0);
    bus.enable = 1;
    step(); step();
    check("restart_dt", 32'(bus.en & ~bus.out_hi & ~bus.out_lo), 32'h7);

    // Randomized run with a real triangle carrier and lock at the extrema.
    tri_v = 0; dir = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tri_v += dir * 128;
      bus.lock = 0;
      if (tri_v >= 4096 || tri_v <= -4096) begin
        dir = -dir; bus.lock = 1;
      end
      bus.triangle = W'(tri_v);
      if ($urandom_range(0, 19) == 0)
        set_refs($urandom_range(0, 9000) - 4500, $urandom_range(0, 9000) - 4500,
                 $urandom_range(0, 9000) - 4500);
      if ($urandom_range(0, 29) == 0) bus.dead_cyc = DT_W'($urandom_range(0, 7));
      bus.trip = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 399) == 0) bus.enable = ~bus.enable;
      else if (!bus.enable && $urandom_range(0, 9) == 0) bus.enable = 1;
      reset = (cyc == 2500);
      step();
      if (cyc == 2500) begin
        check("rst_mid_hi", 32'(bus.out_hi | bus.out_lo | bus.en), 32'd0);
        check("rst_mid_trip", 32'(bus.tripped), 32'd0);
      end
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
